// File: rtl/sw_input_if.sv
`default_nettype none
// ============================================================================
//  Module      : sw_input_if
//  Description : Handshake bundle between the switch debouncer and the
//                CPU IN port.
//                  data     debounced switch value (producer -> consumer)
//                  valid    data holds an unacknowledged value
//                  overrun  a newer value replaced an unacknowledged one
//                  busy     a switch change is still settling
//                  ack      consumer has taken data (consumer -> producer)
//  Revision    : 1.0  initial release
// ============================================================================
interface sw_input_if #(
    parameter int WIDTH = 9
) ();
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             overrun;
    logic             busy;
    logic             ack;

    // Producer side: the debouncer.
    modport master (
        output data,
        output valid,
        output overrun,
        output busy,
        input  ack
    );

    // Consumer side: the CPU IN port.
    modport slave (
        input  data,
        input  valid,
        input  overrun,
        input  busy,
        output ack
    );
endinterface
`default_nettype wire

// File: rtl/sw_input.sv
`default_nettype none
// ============================================================================
//  Module      : sw_input
//  Description : Switch-bank input path. Synchronises the raw switch levels
//                into clk with a two-flop synchroniser, debounces them with a
//                two-state settle FSM and presents each newly committed value
//                on a valid/ack handshake.
//  Ports       : clk      system clock, all registers on rising edge
//                rst_n    asynchronous active-low reset
//                sw       raw switch levels, asynchronous to clk
//                bus      sw_input_if master modport:
//                           data/valid/overrun/busy out, ack in
//  Revision    : 1.0  initial release
// ============================================================================
module sw_input #(
    parameter int WIDTH         = 9,
    parameter int STABLE_CYCLES = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] sw,
    sw_input_if.master            bus
);

    // Counter only ever reaches STABLE_CYCLES-1, so this width never wraps.
    localparam int                 c_cnt_w    = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(STABLE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    typedef enum logic [0:0] {
        ST_STABLE = 1'b0,
        ST_SETTLE = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]   r_sync1;
    logic [WIDTH-1:0]   r_sync2;
    logic [WIDTH-1:0]   r_cand;
    logic [WIDTH-1:0]   r_data;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_valid;
    logic               r_overrun;
    state_t             r_state;

    // ------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------
    state_t             w_state_next;
    logic [WIDTH-1:0]   w_cand_next;
    logic [c_cnt_w-1:0] w_cnt_next;
    logic [WIDTH-1:0]   w_data_next;
    logic               w_valid_next;
    logic               w_overrun_next;
    logic               w_commit;
    logic               w_update;

    // ------------------------------------------------------------------
    // Two-flop synchroniser; only r_sync2 is used downstream.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sw;
            r_sync2 <= r_sync1;
        end
    end

    // ------------------------------------------------------------------
    // Settle FSM: next-state and datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cand_next  = r_cand;
        w_cnt_next   = r_cnt;
        w_commit     = 1'b0;

        case (r_state)
            ST_STABLE: begin
                if (r_sync2 != r_cand) begin
                    w_cand_next  = r_sync2;
                    w_cnt_next   = '0;
                    w_state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (r_sync2 != r_cand) begin
                    // Any glitch during settling restarts the hold count.
                    w_cand_next = r_sync2;
                    w_cnt_next  = '0;
                end else if (r_cnt == c_cnt_last) begin
                    w_commit     = 1'b1;
                    w_state_next = ST_STABLE;
                end else begin
                    w_cnt_next = r_cnt + c_cnt_one;
                end
            end
            default: begin
                w_state_next = ST_STABLE;
            end
        endcase
    end

    // A commit of the already-published value (switch bounced back) is silent.
    assign w_update = w_commit && (r_cand != r_data);

    // ------------------------------------------------------------------
    // Handshake decode. A real update takes priority over ack: the new
    // value stays valid, and overrun records whether the previous value was
    // dropped unconsumed (an ack in the same cycle means it was consumed).
    // ------------------------------------------------------------------
    always_comb begin
        w_data_next    = r_data;
        w_valid_next   = r_valid;
        w_overrun_next = r_overrun;

        if (w_update) begin
            w_data_next    = r_cand;
            w_valid_next   = 1'b1;
            w_overrun_next = r_valid && !bus.ack;
        end else if (bus.ack && r_valid) begin
            w_valid_next   = 1'b0;
            w_overrun_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_STABLE;
            r_cand    <= '0;
            r_cnt     <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cand    <= w_cand_next;
            r_cnt     <= w_cnt_next;
            r_data    <= w_data_next;
            r_valid   <= w_valid_next;
            r_overrun <= w_overrun_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.data    = r_data;
    assign bus.valid   = r_valid;
    assign bus.overrun = r_overrun;
    assign bus.busy    = (r_state == ST_SETTLE);

endmodule
`default_nettype wire
